// File: rtl/knn_topk_vote.sv
// knn_topk_vote: keeps the K nearest (distance, label) samples of a query in a
// sorted register list, then runs a majority vote and reports the winning class.
module knn_topk_vote #(
  parameter int DIST_W  = 64,
  parameter int LABEL_W = 2,
  parameter int NCLASS  = 4,
  parameter int K       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIST_W-1:0]        in_dist,
  input  logic [LABEL_W-1:0]       in_label,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LABEL_W-1:0]       out_label,
  output logic [$clog2(K+1)-1:0]   out_votes,
  output logic                     busy
);

  localparam int VW   = $clog2(K + 1);
  localparam int NMAX = (K > NCLASS) ? K : NCLASS;
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, VOTE, ARGMAX, DONE} state_t;

  state_t state_reg, state_next;
  logic [IW-1:0] idx_reg;

  // Sorted neighbour list; valid entries always form a prefix, smallest first
  logic [K-1:0]       valid_reg;
  logic [DIST_W-1:0]  dist_reg  [K];
  logic [LABEL_W-1:0] label_reg [K];

  logic [VW-1:0]      cnt_reg [NCLASS];
  logic [LABEL_W-1:0] best_label_reg, out_label_reg;
  logic [VW-1:0]      best_votes_reg, out_votes_reg;

  logic accept, start_go, idx_last_vote, idx_last_class;
  logic [K-1:0] ins_here, take_new;

  assign accept         = in_valid && (state_reg == COLLECT);
  assign start_go       = start && (state_reg == IDLE);
  assign idx_last_vote  = (idx_reg == IW'(K - 1));
  assign idx_last_class = (idx_reg == IW'(NCLASS - 1));

  // Parallel compare: a slot is at or behind the insertion point when it is
  // empty or holds a strictly larger distance (equal distances stay ahead).
  // Because the list is sorted this vector is thermometer-shaped, so the
  // insertion point is its lowest set bit.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_cmp
      assign ins_here[gi] = !valid_reg[gi] || (dist_reg[gi] > in_dist);
      if (gi == 0) begin : g_first
        assign take_new[gi] = ins_here[gi];
      end else begin : g_rest
        assign take_new[gi] = ins_here[gi] && !ins_here[gi-1];
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)                state_next = COLLECT;
      COLLECT: if (in_valid && in_last)  state_next = VOTE;
      VOTE:    if (idx_last_vote)        state_next = ARGMAX;
      ARGMAX:  if (idx_last_class)       state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_reg == COLLECT);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
    out_label = out_label_reg;
    out_votes = out_votes_reg;
  end

  // Scan index for VOTE and ARGMAX; restarts at 0 on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          idx_reg <= '0;
    else if (state_next != state_reg)  idx_reg <= '0;
    else if (state_reg == VOTE || state_reg == ARGMAX) idx_reg <= idx_reg + 1'b1;
  end

  // Sorted insertion: new sample lands at the insertion point, entries behind
  // it move down one slot, slot K-1 falls off. No insertion point = discard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      for (int i = 0; i < K; i++) begin
        dist_reg[i]  <= '0;
        label_reg[i] <= '0;
      end
    end else if (start_go) begin
      valid_reg <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        if (take_new[i]) begin
          valid_reg[i] <= 1'b1;
          dist_reg[i]  <= in_dist;
          label_reg[i] <= in_label;
        end else if (ins_here[i]) begin
          valid_reg[i] <= valid_reg[(i == 0) ? 0 : i - 1];
          dist_reg[i]  <= dist_reg[(i == 0) ? 0 : i - 1];
          label_reg[i] <= label_reg[(i == 0) ? 0 : i - 1];
        end
      end
    end
  end

  // Entry and counter selected by the scan index
  logic               vote_valid;
  logic [LABEL_W-1:0] vote_label;
  logic [VW-1:0]      scan_cnt;
  always_comb begin
    vote_valid = 1'b0;
    vote_label = '0;
    scan_cnt   = '0;
    for (int i = 0; i < K; i++) begin
      if (idx_reg == IW'(i)) begin
        vote_valid = valid_reg[i];
        vote_label = label_reg[i];
      end
    end
    for (int c = 0; c < NCLASS; c++) begin
      if (idx_reg == IW'(c)) scan_cnt = cnt_reg[c];
    end
  end

  // Vote counters; a label >= NCLASS matches no counter and so casts no vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCLASS; c++) cnt_reg[c] <= '0;
    end else if (start_go) begin
      for (int c = 0; c < NCLASS; c++) cnt_reg[c] <= '0;
    end else if (state_reg == VOTE && vote_valid) begin
      for (int c = 0; c < NCLASS; c++) begin
        if ({1'b0, vote_label} == (LABEL_W + 1)'(c)) cnt_reg[c] <= cnt_reg[c] + 1'b1;
      end
    end
  end

  // Argmax: strictly-greater replacement keeps ties on the lowest label
  logic               better;
  logic [LABEL_W-1:0] cand_label;
  logic [VW-1:0]      cand_votes;
  assign better     = scan_cnt > best_votes_reg;
  assign cand_label = better ? LABEL_W'(idx_reg) : best_label_reg;
  assign cand_votes = better ? scan_cnt : best_votes_reg;

  // Running best during ARGMAX; the visible result is latched on the last class
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_label_reg <= '0;
      best_votes_reg <= '0;
      out_label_reg  <= '0;
      out_votes_reg  <= '0;
    end else if (state_reg == VOTE) begin
      best_label_reg <= '0;
      best_votes_reg <= '0;
    end else if (state_reg == ARGMAX) begin
      best_label_reg <= cand_label;
      best_votes_reg <= cand_votes;
      if (idx_last_class) begin
        out_label_reg <= cand_label;
        out_votes_reg <= cand_votes;
      end
    end
  end

endmodule

// File: tb/tb_knn_topk_vote.sv
// Randomized and directed checks of knn_topk_vote against a sort-and-count model.
module tb_knn_topk_vote;

  localparam int DIST_W  = 64;
  localparam int LABEL_W = 2;
  localparam int NCLASS  = 4;
  localparam int K       = 4;
  localparam int VW      = $clog2(K + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DIST_W-1:0]  in_dist = '0;
  logic [LABEL_W-1:0] in_label = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [LABEL_W-1:0] out_label;
  logic [VW-1:0]      out_votes;
  logic               busy;

  knn_topk_vote #(.DIST_W(DIST_W), .LABEL_W(LABEL_W), .NCLASS(NCLASS), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
    .in_label(in_label), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .out_votes(out_votes), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int n_query  = 0;

  logic [DIST_W-1:0]  qd[$];
  logic [LABEL_W-1:0] ql[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: K smallest distances with earlier arrival winning ties,
  // majority label among them, ties resolved to the lowest label.
  task automatic model(output int el, output int ev);
    int n;
    int best;
    int cnt[NCLASS];
    bit used[];
    n = qd.size();
    used = new[n];
    for (int c = 0; c < NCLASS; c++) cnt[c] = 0;
    for (int k = 0; k < K; k++) begin
      best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || qd[j] < qd[best])) best = j;
      if (best >= 0) begin
        used[best] = 1'b1;
        if (int'(ql[best]) < NCLASS) cnt[ql[best]]++;
      end
    end
    el = 0;
    ev = cnt[0];
    for (int c = 1; c < NCLASS; c++)
      if (cnt[c] > ev) begin
        el = c;
        ev = cnt[c];
      end
  endtask

  task automatic add(input logic [DIST_W-1:0] d, input logic [LABEL_W-1:0] l);
    qd.push_back(d);
    ql.push_back(l);
  endtask

  // Runs the query held in qd/ql; returns at #1 after the edge back to IDLE
  task automatic run_query(input int bp_cycles, input bit start_noise);
    int el, ev, lat, n;
    n = qd.size();
    model(el, ev);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_collect", busy, 1);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_dist  = qd[j];
      in_label = ql[j];
      in_last  = (j == n - 1);
      start    = start_noise;
      check("in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    check("in_ready_off", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, K + NCLASS);
    check("out_label", out_label, el);
    check("out_votes", out_votes, ev);
    for (int b = 0; b < bp_cycles; b++) begin
      start = start_noise;
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_label", out_label, el);
      check("bp_votes", out_votes, ev);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("busy_idle", busy, 0);
    check("idle_label", out_label, el);
    $display("query %0d: n=%0d bp=%0d label=%0d votes=%0d lat=%0d", n_query, n, bp_cycles, out_label, out_votes, lat);
    n_query++;
    qd.delete();
    ql.delete();
  endtask

  initial begin
    int n, mode;
    // Reset state
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_label", out_label, 0);
    check("rst_votes", out_votes, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic stream
    add(50, 1); add(10, 2); add(30, 2); add(40, 3); add(5, 0); add(20, 1);
    run_query(0, 1'b0);
    // Fewer than K samples
    add(7, 3); add(7, 1); add(9, 1);
    run_query(1, 1'b0);
    // Vote tie
    add(1, 3); add(2, 1); add(3, 3); add(4, 1);
    run_query(0, 1'b0);
    // Equal-distance ordering
    add(8, 1); add(8, 1); add(8, 2); add(8, 2); add(8, 2);
    run_query(0, 1'b0);
    // Backpressure with start noise in COLLECT/DONE
    add(12, 3); add(3, 3); add(99, 0); add(4, 2);
    run_query(5, 1'b1);

    // Reset mid-VOTE: outputs must clear before the next edge
    add(4, 3); add(6, 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_dist = qd[j]; in_label = ql[j]; in_last = (j == 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_label", out_label, 0);
    check("arst_votes", out_votes, 0);
    qd.delete();
    ql.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    add(3, 2);
    run_query(0, 1'b0);

    // Randomized queries
    for (int q = 0; q < 40; q++) begin
      n = $urandom_range(1, 10);
      mode = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        if (mode == 0)
          add(DIST_W'($urandom_range(0, 15)), LABEL_W'($urandom_range(0, NCLASS - 1)));
        else
          add({$urandom, $urandom}, LABEL_W'($urandom_range(0, NCLASS - 1)));
      end
      run_query($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/knn_topk_vote.md
Name: knn_topk_vote

Overview:
- Consumer end of the squared-distance stream produced by the KNN distance core.
- Accepts one (distance, label) pair per cycle over a valid/ready handshake and keeps the K smallest distances in a sorted register list.
- On the last sample it counts label votes over the kept entries and reports the winning class over a valid/ready output handshake.
- Sits between the distance core and the KNN register/software interface.

Parameters:
DIST_W, 64, width of incoming squared distance (2x the point coordinate width)
LABEL_W, 2, width of class label
NCLASS, 4, number of classes (labels 0..NCLASS-1), NCLASS <= 2**LABEL_W
K, 4, number of nearest neighbours kept, K >= 1

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle pulse: clear list and counters, begin collecting; honoured only in IDLE
in_valid  input  1  in_dist/in_label/in_last valid
in_ready  output  1  block accepts a sample this cycle
in_dist  input  DIST_W  unsigned squared distance
in_label  input  LABEL_W  class of the sample
in_last  input  1  marks final sample of the query
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
out_label  output  LABEL_W  winning class
out_votes  output  $clog2(K+1)  vote count of the winning class
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all list entries invalid; vote counters 0; in_ready=0, out_valid=0, out_label=0, out_votes=0, busy=0.
- States: IDLE -> COLLECT -> VOTE -> ARGMAX -> DONE -> IDLE.
- IDLE: start=1 clears list valid bits and counters, goes to COLLECT. Other inputs are ignored.
- COLLECT: in_ready=1. A sample is accepted when in_valid&in_ready, one per cycle, with no bubbles.
- Insertion: single cycle; parallel compare of in_dist against all entries.
  - The new entry is placed before the first valid entry with strictly greater distance, or into the first invalid slot.
  - Entries behind it shift one slot down; the entry in slot K-1 is dropped if the list is full.
  - Equal distances: the earlier arrival stays ahead.
  - A sample not smaller than a full list's slot K-1 is discarded.
- Accepting in_last (edge 0) -> VOTE. in_ready=0 from then on. start is ignored outside IDLE.
- VOTE: K cycles, index i=0..K-1. When entry i is valid, counter[label_i] increments. Invalid entries (fewer than K samples) do not vote. Labels >= NCLASS are not counted.
- ARGMAX: NCLASS cycles, scanning c=0..NCLASS-1. A class replaces the best only on a strictly greater count, so ties go to the lowest label.
- DONE is entered at edge K+NCLASS after the in_last acceptance. out_valid=1 there, with out_label/out_votes stable.
- DONE: out_valid stays high, and outputs stay held, until out_ready=1. That edge -> IDLE, and out_valid drops.
  - out_label/out_votes keep their last values in IDLE.
- Comparisons are unsigned over the full DIST_W; no saturation.
- Counters are $clog2(K+1) wide and cannot overflow.
- rst asserted in any state aborts immediately to reset values. No partial result is produced.

Test Plan:
- K=4,NCLASS=4: start; stream (50,L1),(10,L2),(30,L2),(40,L3),(5,L0),(20,L1,last) with in_valid held high -> in_ready high for all 6 cycles; kept list 5,10,20,30; out_valid rises 8 edges after the last acceptance; out_label=2, out_votes=2.
- Fewer than K samples: (7,L3),(7,L1),(9,L1,last) -> only 3 entries vote; out_label=1, out_votes=2.
- Vote tie: (1,L3),(2,L1),(3,L3),(4,L1,last) -> 2-2 tie; out_label=1 (lowest label), out_votes=2.
- Equal-distance ordering: five samples dist 8, labels 1,1,2,2,2(last) -> fifth dropped; out_label=1, out_votes=2 (a result of label 2 indicates wrong tie ordering).
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable; out_ready=1 -> IDLE next edge, busy=0. start in COLLECT/DONE has no effect.
- Reset mid-operation: rst=0 during VOTE -> all outputs return to 0 asynchronously (before the next edge). After release, a new start plus a single sample (3,L2,last) -> out_label=2, out_votes=1.
